// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-ported unified memory between instruction fetch and data access.
// Data has fixed priority, a wait counter bounds every access, and the pipeline is stalled until completion.
module mem_port_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err,
    output logic [1:0]        state_dbg
);

    // Handshakes: requesters hold their request level until the one-cycle done pulse
    // (d_done / if_rvalid); the memory answers a held mem_req with a one-cycle mem_ack.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        I_BUSY = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              we_q;
    logic              resp_is_data_q;
    logic              err_q;
    logic [CNT_W-1:0]  wait_q;
    logic [CNT_W-1:0]  wait_inc;

    logic accept_d;
    logic accept_i;
    logic capture_resp;
    logic timed_out;
    logic set_err;
    logic busy;

    assign busy     = (state == D_BUSY) || (state == I_BUSY);
    assign wait_inc = wait_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        accept_d     = 1'b0;
        accept_i     = 1'b0;
        capture_resp = 1'b0;
        timed_out    = 1'b0;
        set_err      = 1'b0;
        case (state)
            IDLE: begin
                if (d_read || d_write) begin
                    state_next = D_BUSY;
                    accept_d   = 1'b1;
                    // A simultaneous load and store is resolved as a store and flagged.
                    set_err    = d_read && d_write;
                end else if (if_req) begin
                    state_next = I_BUSY;
                    accept_i   = 1'b1;
                end
            end
            D_BUSY, I_BUSY: begin
                if (mem_ack) begin
                    state_next   = RESP;
                    capture_resp = 1'b1;
                end else if (wait_inc == CNT_W'(TIMEOUT)) begin
                    state_next = RESP;
                    timed_out  = 1'b1;
                    set_err    = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q         <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            we_q           <= 1'b0;
            resp_is_data_q <= 1'b0;
            err_q          <= 1'b0;
            wait_q         <= '0;
        end else begin
            if (accept_d) begin
                addr_q         <= d_addr;
                wdata_q        <= d_wdata;
                we_q           <= d_write;
                resp_is_data_q <= 1'b1;
                wait_q         <= '0;
            end else if (accept_i) begin
                addr_q         <= if_addr;
                wdata_q        <= '0;
                we_q           <= 1'b0;
                resp_is_data_q <= 1'b0;
                wait_q         <= '0;
            end else if (busy && !mem_ack) begin
                wait_q <= wait_inc;
            end
            if (capture_resp) begin
                rdata_q <= mem_rdata;
            end else if (timed_out) begin
                rdata_q <= '0;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    // All memory-side outputs come from registers so they hold steady across wait states.
    assign mem_req   = busy;
    assign mem_we    = we_q && busy;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign d_done    = (state == RESP) && resp_is_data_q;
    assign if_rvalid = (state == RESP) && !resp_is_data_q;
    assign d_rdata   = rdata_q;
    assign if_rdata  = rdata_q;

    assign stall_mem = (d_read || d_write) && !d_done;
    assign stall_if  = (if_req && !if_rvalid) || stall_mem;

    assign err       = err_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every cycle,
// an address-order scoreboard, and literal expectations per scenario.
module tb_mem_port_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int TO = 16;

    // clock / reset
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          if_req   = 1'b0;
    logic [AW-1:0] if_addr  = '0;
    logic          d_read   = 1'b0;
    logic          d_write  = 1'b0;
    logic [AW-1:0] d_addr   = '0;
    logic [DW-1:0] d_wdata  = '0;
    logic          mem_ack  = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          if_rvalid, d_done, stall_if, stall_mem, mem_req, mem_we, err;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    state_dbg;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .err(err), .state_dbg(state_dbg)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // memory responder: ack in the (ack_delay+1)-th request cycle; -1 never acks
    int          ack_delay = 0;
    logic [DW-1:0] ack_data = '0;
    bit          by_addr   = 1'b0;
    bit          force_ack = 1'b0;

    initial begin : responder
        int run;
        run = 0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_req) run++;
            else run = 0;
            mem_ack = force_ack || (mem_req && ack_delay >= 0 && run == ack_delay + 1);
            if (mem_ack) mem_rdata = by_addr ? {16'hC0DE, 7'd0, mem_addr} : ack_data;
            else mem_rdata = $urandom();
        end
    end

    // behavioural model: one access in flight, one response cycle, sticky error
    bit            m_busy = 0, m_resp = 0, m_resp_is_data = 0, m_we = 0, m_err = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0;
    int            m_waited = 0;

    // monitors and scoreboard
    logic [AW-1:0] exp_q[$];
    bit            prev_req = 0;
    int            req_cycles = 0, we_cycles = 0, d_pulses = 0, i_pulses = 0;
    logic [DW-1:0] last_d = '0, last_i = '0;

    always @(negedge clk) begin : compare
        logic          e_req, e_dd, e_iv, e_smem;
        logic [AW-1:0] exp_addr;
        e_req  = reset && m_busy;
        e_dd   = reset && m_resp && m_resp_is_data;
        e_iv   = reset && m_resp && !m_resp_is_data;
        e_smem = (d_read || d_write) && !e_dd;
        check("mem_req", 32'(mem_req), 32'(e_req));
        check("d_done", 32'(d_done), 32'(e_dd));
        check("if_rvalid", 32'(if_rvalid), 32'(e_iv));
        check("stall_mem", 32'(stall_mem), 32'(e_smem));
        check("stall_if", 32'(stall_if), 32'((if_req && !e_iv) || e_smem));
        check("err", 32'(err), 32'(reset && m_err));
        if (e_req) begin
            check("mem_addr", 32'(mem_addr), 32'(m_addr));
            check("mem_we", 32'(mem_we), 32'(m_we));
            if (m_we) check("mem_wdata", mem_wdata, m_wdata);
        end
        if (e_dd) check("d_rdata", d_rdata, m_rdata);
        if (e_iv) check("if_rdata", if_rdata, m_rdata);

        if (mem_req && !prev_req && exp_q.size() > 0) begin
            exp_addr = exp_q.pop_front();
            check("mem_addr_seq", 32'(mem_addr), 32'(exp_addr));
        end
        prev_req = mem_req;
        if (mem_req) req_cycles++;
        if (mem_req && mem_we) we_cycles++;
        if (d_done) begin d_pulses++; last_d = d_rdata; end
        if (if_rvalid) begin i_pulses++; last_i = if_rdata; end

        if (!reset) begin
            m_busy = 0; m_resp = 0; m_err = 0; m_waited = 0;
        end else if (m_resp) begin
            m_resp = 0;
        end else if (m_busy) begin
            if (mem_ack) begin
                m_busy = 0; m_resp = 1; m_rdata = mem_rdata;
            end else begin
                m_waited++;
                if (m_waited == TO) begin
                    m_busy = 0; m_resp = 1; m_rdata = '0; m_err = 1;
                end
            end
        end else if (d_read || d_write) begin
            m_busy = 1; m_resp_is_data = 1; m_we = d_write;
            m_addr = d_addr; m_wdata = d_wdata; m_waited = 0;
            if (d_read && d_write) m_err = 1;
        end else if (if_req) begin
            m_busy = 1; m_resp_is_data = 0; m_we = 0; m_addr = if_addr; m_waited = 0;
        end
    end

    // driver: keep requests held until their done pulse, then release them
    task automatic serve(input int budget);
        int cyc;
        bit drop_d, drop_i;
        cyc = 0;
        while ((d_read || d_write || if_req) && cyc < budget) begin
            @(negedge clk);
            drop_d = d_done;
            drop_i = if_rvalid;
            @(posedge clk);
            #1;
            if (drop_d) begin d_read = 0; d_write = 0; end
            if (drop_i) if_req = 0;
            cyc++;
        end
        checks++;
        if (d_read || d_write || if_req) begin
            errors++;
            $display("FAIL serve_budget: request still pending after %0d cycles, required completion", budget);
            d_read = 0; d_write = 0; if_req = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int r0, w0, d0, i0;
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        idle(2);

        // fetch, ack one cycle after mem_req rises
        ack_delay = 1; ack_data = 32'h00500093; by_addr = 0;
        r0 = req_cycles; i0 = i_pulses;
        if_req = 1; if_addr = 9'h004;
        serve(20);
        idle(2);
        check("fetch_pulses", i_pulses - i0, 32'd1);
        check("fetch_rdata", last_i, 32'h00500093);
        check("fetch_req_cycles", req_cycles - r0, 32'd2);

        // collision: data first, then the fetch
        ack_delay = 0; by_addr = 1;
        d0 = d_pulses; i0 = i_pulses;
        exp_q.push_back(9'h010);
        exp_q.push_back(9'h004);
        d_read = 1; d_addr = 9'h010; if_req = 1; if_addr = 9'h004;
        serve(40);
        idle(2);
        check("coll_d_pulses", d_pulses - d0, 32'd1);
        check("coll_i_pulses", i_pulses - i0, 32'd1);
        check("coll_d_rdata", last_d, 32'hC0DE0010);
        check("coll_i_rdata", last_i, 32'hC0DE0004);
        check("coll_seq_drained", 32'(exp_q.size()), 32'd0);

        // store with three wait states
        ack_delay = 3; by_addr = 0; ack_data = 32'h11112222;
        r0 = req_cycles; w0 = we_cycles; d0 = d_pulses;
        d_write = 1; d_addr = 9'h020; d_wdata = 32'hDEADBEEF;
        serve(30);
        idle(2);
        check("store_req_cycles", req_cycles - r0, 32'd4);
        check("store_we_cycles", we_cycles - w0, 32'd4);
        check("store_pulses", d_pulses - d0, 32'd1);
        check("store_err", 32'(err), 32'd0);

        // spurious ack while idle
        r0 = req_cycles; d0 = d_pulses; i0 = i_pulses;
        force_ack = 1;
        idle(3);
        force_ack = 0;
        idle(2);
        check("spur_req", req_cycles - r0, 32'd0);
        check("spur_pulses", (d_pulses - d0) + (i_pulses - i0), 32'd0);

        // timeout: no ack at all
        ack_delay = -1;
        r0 = req_cycles; d0 = d_pulses;
        d_read = 1; d_addr = 9'h030;
        serve(40);
        idle(2);
        check("to_req_cycles", req_cycles - r0, 32'd16);
        check("to_pulses", d_pulses - d0, 32'd1);
        check("to_rdata", last_d, 32'd0);
        check("to_err", 32'(err), 32'd1);

        // err stays set across a normal access
        ack_delay = 0; ack_data = 32'h12345678;
        if_req = 1; if_addr = 9'h008;
        serve(20);
        idle(2);
        check("to_err_sticky", 32'(err), 32'd1);
        check("after_to_rdata", last_i, 32'h12345678);

        // reset during D_BUSY
        ack_delay = -1;
        d_read = 1; d_addr = 9'h050;
        idle(3);
        reset = 0; d_read = 0;
        @(negedge clk);
        check("rst_drops_req", 32'(mem_req), 32'd0);
        check("rst_clears_err", 32'(err), 32'd0);
        idle(2);
        reset = 1;
        d0 = d_pulses;
        idle(5);
        check("rst_no_done", d_pulses - d0, 32'd0);
        ack_delay = 1; ack_data = 32'h600DCAFE;
        d_read = 1; d_addr = 9'h060;
        serve(20);
        idle(2);
        check("rst_next_pulses", d_pulses - d0, 32'd1);
        check("rst_next_rdata", last_d, 32'h600DCAFE);

        // simultaneous load and store resolves as a store and flags err
        ack_delay = 0; ack_data = 32'h0;
        w0 = we_cycles; d0 = d_pulses;
        d_read = 1; d_write = 1; d_addr = 9'h040; d_wdata = 32'h0BADF00D;
        serve(20);
        idle(2);
        check("rw_we_cycles", we_cycles - w0, 32'd1);
        check("rw_pulses", d_pulses - d0, 32'd1);
        check("rw_err", 32'(err), 32'd1);

        $display("final arbiter state code %0d", state_dbg);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, width of the word address.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter TIMEOUT, default 16, maximum number of cycles that mem_req may wait for mem_ack.
REQ-004 Port clk, input, 1 bit: single clock; every register updates on the rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port if_req, input, 1 bit: instruction fetch request; held by the fetch stage until if_rvalid.
REQ-007 Port if_addr, input, ADDR_W bits: fetch address.
REQ-008 Port if_rvalid, output, 1 bit: one-cycle pulse; fetch completed.
REQ-009 Port if_rdata, output, DATA_W bits: fetched instruction, valid while if_rvalid is high.
REQ-010 Port d_read, input, 1 bit: data load request (decoder MemRead); held until d_done.
REQ-011 Port d_write, input, 1 bit: data store request (decoder MemWrite); held until d_done.
REQ-012 Port d_addr, input, ADDR_W bits: data address.
REQ-013 Port d_wdata, input, DATA_W bits: store data.
REQ-014 Port d_done, output, 1 bit: one-cycle pulse; data access completed.
REQ-015 Port d_rdata, output, DATA_W bits: load data, valid while d_done is high.
REQ-016 Port stall_if, output, 1 bit: freeze the IF stage.
REQ-017 Port stall_mem, output, 1 bit: freeze the MEM stage and all older stages.
REQ-018 Port mem_req, output, 1 bit: request to the single-ported unified memory.
REQ-019 Port mem_we, output, 1 bit: 1 = write.
REQ-020 Port mem_addr, output, ADDR_W bits: memory address.
REQ-021 Port mem_wdata, output, DATA_W bits: memory write data.
REQ-022 Port mem_ack, input, 1 bit: one-cycle acknowledge; mem_rdata is valid in the same cycle.
REQ-023 Port mem_rdata, input, DATA_W bits: memory read data.
REQ-024 Port err, output, 1 bit: sticky error flag.

Function
REQ-025 The FSM SHALL have four states: IDLE, D_BUSY, I_BUSY, RESP.
REQ-026 In IDLE, if d_read or d_write is high, the FSM SHALL go to D_BUSY; otherwise, if if_req is high, to I_BUSY; otherwise it SHALL stay in IDLE. Data requests have fixed priority over fetch.
REQ-027 On acceptance, the FSM SHALL capture the address, write data and we (we = d_write for data, 0 for fetch) into registers; mem_* outputs SHALL be driven only from these registers.
REQ-028 mem_req SHALL be 1 exactly while the FSM is in D_BUSY or I_BUSY; mem_addr, mem_we and mem_wdata SHALL stay stable while mem_req is high.
REQ-029 When mem_ack is high in a BUSY state, the FSM SHALL register mem_rdata and go to RESP.
REQ-030 In RESP, the block SHALL pulse d_done (after D_BUSY) or if_rvalid (after I_BUSY) for exactly one cycle, then go to IDLE; RESP SHALL never accept a request.
REQ-031 Latency: request accepted in cycle N; mem_req high from N+1; mem_ack in cycle M ≥ N+1; done pulse in M+1; next acceptance no earlier than M+2.
REQ-032 stall_mem SHALL equal (d_read | d_write) & ~d_done, combinationally.
REQ-033 stall_if SHALL equal (if_req & ~if_rvalid) | stall_mem, combinationally.
REQ-034 If d_read and d_write are both high at acceptance, the block SHALL perform a write and set err.
REQ-035 A 5-bit-or-wider wait counter SHALL clear on entry to a BUSY state and increment every BUSY cycle without mem_ack.
REQ-036 If the wait counter reaches TIMEOUT, the FSM SHALL go to RESP with the response data forced to 0 and SHALL set err.
REQ-037 mem_ack outside a BUSY state SHALL be ignored, with no state change.
REQ-038 err SHALL remain set until reset.

Reset
REQ-039 While reset is low, asynchronously: FSM = IDLE; mem_req, mem_we, d_done, if_rvalid and err = 0; captured address, write data, response data and wait counter = 0.
REQ-040 Reset asserted mid-transaction SHALL drop mem_req immediately, and the abandoned access SHALL never produce a done pulse.

Verification
REQ-041 Fetch: if_req=1, if_addr=0x004; mem_ack one cycle after mem_req with rdata=0x00500093 -> if_rvalid pulses once with if_rdata=0x00500093; stall_if=1 until that cycle.
REQ-042 Collision: d_read=1, d_addr=0x010 and if_req=1 in the same cycle -> data is served first, d_done, then the fetch of if_addr; mem_addr sequence is 0x010 then if_addr.
REQ-043 Store: d_write=1, d_addr=0x020, d_wdata=0xDEADBEEF; mem_ack held off 3 cycles -> mem_we=1 and mem_addr/mem_wdata stable for all 4 request cycles; single d_done pulse.
REQ-044 Timeout: TIMEOUT=16, mem_ack never asserted -> mem_req drops after 16 cycles; done pulse with rdata=0; err=1 and stays set.
REQ-045 Reset mid-operation: reset low during D_BUSY -> mem_req=0 in the same cycle; no d_done pulse after release; next request is served normally.
REQ-046 Spurious ack: mem_ack=1 while in IDLE -> no done pulse; state and outputs unchanged.
